// File: rtl/tiny_io_stim.sv
// Wishbone stimulus/capture stage: steps a slow clock into the tiny user module and captures its output.
// Optional completion interrupt (stim_irq, CTRL.IRQ_EN) is built when TINY_IO_STIM_IRQ_EN is defined.
module tiny_io_stim #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned STEP_W    = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  tiny_in,
    input  logic [7:0]  tiny_out
`ifdef TINY_IO_STIM_IRQ_EN
    ,
    output logic        stim_irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_DIN   = 8'h04;
    localparam logic [7:0] OFF_DIV   = 8'h08;
    localparam logic [7:0] OFF_STEPS = 8'h0C;
    localparam logic [7:0] OFF_DOUT  = 8'h10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel_v);
        logic [31:0] res_v;
        for (int i = 0; i < 4; i++) begin
            res_v[i*8 +: 8] = sel_v[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res_v;
    endfunction

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                clk_gen_q, clk_gen_d;
    logic                done_q, done_d;
    logic                rst_out_q, rst_out_d;
    logic [5:0]          din_q, din_d;
    logic [7:0]          dout_q, dout_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;

    logic                access_s;
    logic                wr_s;
    logic                ctrl_wr_s;
    logic                start_s;
    logic                abort_s;
    logic                done_clr_s;
    logic                busy_s;
    logic                irq_en_bit_s;
    logic [7:0]          off_s;
    logic [31:0]         rdata_s;
    logic [31:0]         div_wr_s;
    logic [31:0]         steps_wr_s;
    logic                unused_s;

    // Writes are committed in the ack cycle, so they take effect the cycle after the ack.
    assign access_s   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_s       = access_s & wbs_we_i & ack_q;
    assign off_s      = wbs_adr_i[7:0];
    assign ctrl_wr_s  = wr_s & (off_s == OFF_CTRL) & wbs_sel_i[0];
    assign start_s    = ctrl_wr_s & wbs_dat_i[0];
    assign done_clr_s = ctrl_wr_s & wbs_dat_i[2];
    assign abort_s    = ctrl_wr_s & wbs_dat_i[4];
    assign busy_s     = (state_q != ST_IDLE);
    assign div_wr_s   = merge_bytes(32'(div_q), wbs_dat_i, wbs_sel_i);
    assign steps_wr_s = merge_bytes(32'(steps_q), wbs_dat_i, wbs_sel_i);
    assign unused_s   = ^{div_wr_s, steps_wr_s};

    assign tiny_in    = {din_q, rst_out_q, clk_gen_q};
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;

    // Software-visible configuration registers.
    always_comb begin
        din_d     = din_q;
        rst_out_d = rst_out_q;
        div_d     = div_q;
        if (wr_s && (off_s == OFF_DIN) && wbs_sel_i[0]) begin
            din_d = wbs_dat_i[5:0];
        end else begin
            din_d = din_q;
        end
        if (ctrl_wr_s) begin
            rst_out_d = wbs_dat_i[3];
        end else begin
            rst_out_d = rst_out_q;
        end
        if (wr_s && (off_s == OFF_DIV) && !busy_s) begin
            div_d = div_wr_s[DIV_W-1:0];
        end else begin
            div_d = div_q;
        end
    end

    // Step sequencer: HIGH and LOW each last DIV+1 cycles; DONE set after the last LOW phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_gen_d = clk_gen_q;
        steps_d   = steps_q;
        dout_d    = dout_q;
        done_d    = done_q;
        if (wr_s && (off_s == OFF_STEPS) && !busy_s) begin
            steps_d = steps_wr_s[STEP_W-1:0];
        end else begin
            steps_d = steps_q;
        end
        if (done_clr_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_s && !abort_s) begin
                    if (steps_q != {STEP_W{1'b0}}) begin
                        state_d   = ST_HIGH;
                        cnt_d     = {DIV_W{1'b0}};
                        clk_gen_d = 1'b1;
                        done_d    = 1'b0;
                    end else begin
                        done_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (abort_s) begin
                    state_d   = ST_IDLE;
                    clk_gen_d = 1'b0;
                    cnt_d     = {DIV_W{1'b0}};
                end else if (cnt_q == div_q) begin
                    dout_d    = tiny_out;
                    state_d   = ST_LOW;
                    clk_gen_d = 1'b0;
                    cnt_d     = {DIV_W{1'b0}};
                end else begin
                    cnt_d     = cnt_q + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (abort_s) begin
                    state_d   = ST_IDLE;
                    clk_gen_d = 1'b0;
                    cnt_d     = {DIV_W{1'b0}};
                end else if (cnt_q == div_q) begin
                    steps_d = steps_q - STEP_W'(1);
                    cnt_d   = {DIV_W{1'b0}};
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_HIGH;
                        clk_gen_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_gen_d = 1'b0;
                cnt_d     = {DIV_W{1'b0}};
            end
        endcase
    end

    // Read mux and single-cycle ack; the idle cycle after each ack blocks back-to-back acks.
    always_comb begin
        rdata_s = 32'h0;
        case (off_s)
            OFF_CTRL:  rdata_s = {26'h0, irq_en_bit_s, 1'b0, rst_out_q, done_q, busy_s, 1'b0};
            OFF_DIN:   rdata_s = {26'h0, din_q};
            OFF_DIV:   rdata_s = 32'(div_q);
            OFF_STEPS: rdata_s = 32'(steps_q);
            OFF_DOUT:  rdata_s = {24'h0, dout_q};
            default:   rdata_s = 32'h0;
        endcase
        ack_d = access_s & ~ack_q;
        if (ack_d) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0;
        end
    end

    // State register for bus, configuration and sequencer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {DIV_W{1'b0}};
            div_q     <= {DIV_W{1'b0}};
            steps_q   <= {STEP_W{1'b0}};
            clk_gen_q <= 1'b0;
            done_q    <= 1'b0;
            rst_out_q <= 1'b0;
            din_q     <= 6'h00;
            dout_q    <= 8'h00;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            steps_q   <= steps_d;
            clk_gen_q <= clk_gen_d;
            done_q    <= done_d;
            rst_out_q <= rst_out_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

`ifdef TINY_IO_STIM_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq_en_bit_s = irq_en_q;
    assign stim_irq     = irq_q;

    // Interrupt follows DONE gated by IRQ_EN, one cycle late.
    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr_s) begin
            irq_en_d = wbs_dat_i[5];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = done_q & irq_en_q;
    end

    // Interrupt registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en_bit_s = 1'b0;
`endif

endmodule
